// File: rtl/bt_resp_rcv.sv
// UART receiver and response-line assembler for a Bluetooth module ("AOK"/"ERR" detection).
// Optional idle timeout on partial lines when BT_RESP_TIMEOUT_EN is defined.
module bt_resp_rcv #(
  parameter int BAUD_DIV = 434,
  parameter int MAX_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_resp,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       resp_rcvd,
  output logic       resp_ok,
  output logic       resp_err,
  output logic [3:0] resp_len,
  output logic       overflow,
  output logic       timeout
);

  localparam int              CW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]   HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [3:0]      MAX_L   = 4'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_rx_s1, r_rx_s2, r_rx_d;
  logic [CW-1:0]   r_baud_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_rx_byte;
  logic            r_rx_rdy;
  logic            w_fall, w_cnt_clr, w_shift_en, w_byte_ok;

  logic [7:0]      r_buf [MAX_LEN];
  logic [3:0]      r_len;
  logic            r_ovf_mark;
  logic            r_resp_rcvd, r_resp_ok, r_resp_err, r_overflow;
  logic [3:0]      r_resp_len;
  logic            w_is_lf, w_is_cr, w_complete, w_store, w_clr_eff, w_timeout;
  logic            w_ok_match, w_err_match, w_mark_base;
  logic [3:0]      w_len_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  assign w_fall = r_rx_d & ~r_rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_byte_ok   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_cnt_clr   = 1'b1;
        end
      end
      START: begin
        if (r_baud_cnt == HALF_M1) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = r_rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_baud_cnt == FULL_M1) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_baud_cnt == FULL_M1) begin
          w_cnt_clr   = 1'b1;
          w_byte_ok   = r_rx_s2;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_rx_byte  <= 8'h00;
      r_rx_rdy   <= 1'b0;
    end else begin
      if (r_state == IDLE || w_cnt_clr) r_baud_cnt <= '0;
      else                              r_baud_cnt <= r_baud_cnt + 1'b1;
      if (r_state != DATA)  r_bit_cnt <= 3'd0;
      else if (w_shift_en)  r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift_en) r_shift <= {r_rx_s2, r_shift[7:1]};
      r_rx_rdy <= w_byte_ok;
      if (w_byte_ok) r_rx_byte <= r_shift;
    end
  end

  assign w_is_lf     = (r_rx_byte == 8'h0A);
  assign w_is_cr     = (r_rx_byte == 8'h0D);
  assign w_complete  = r_rx_rdy & w_is_cr & (r_len != 4'd0);
  assign w_store     = r_rx_rdy & ~w_is_lf & ~w_is_cr;
  // A completing line owns the held outputs both on its update edge and while resp_rcvd is shown.
  assign w_clr_eff   = clr_resp & ~w_complete & ~r_resp_rcvd;
  assign w_len_base  = w_clr_eff ? 4'd0 : r_len;
  assign w_mark_base = w_clr_eff ? 1'b0 : r_ovf_mark;
  assign w_ok_match  = (r_len == 4'd3) && !r_ovf_mark &&
                       (r_buf[0] == 8'h41) && (r_buf[1] == 8'h4F) && (r_buf[2] == 8'h4B);
  assign w_err_match = (r_len == 4'd3) && !r_ovf_mark &&
                       (r_buf[0] == 8'h45) && (r_buf[1] == 8'h52) && (r_buf[2] == 8'h52);

`ifdef BT_RESP_TIMEOUT_EN
  logic [19:0] r_idle_cnt;

  assign w_timeout = (r_idle_cnt == 20'hFFFFF) & ~r_rx_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       r_idle_cnt <= 20'd0;
    else if (r_rx_rdy || r_len == 4'd0 || w_timeout) r_idle_cnt <= 20'd0;
    else                                              r_idle_cnt <= r_idle_cnt + 20'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= 8'h00;
      r_len       <= 4'd0;
      r_ovf_mark  <= 1'b0;
      r_resp_rcvd <= 1'b0;
      r_resp_ok   <= 1'b0;
      r_resp_err  <= 1'b0;
      r_resp_len  <= 4'd0;
      r_overflow  <= 1'b0;
    end else begin
      r_resp_rcvd <= w_complete;
      r_len       <= w_len_base;
      r_ovf_mark  <= w_mark_base;
      if (w_clr_eff) begin
        for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= 8'h00;
        r_resp_ok  <= 1'b0;
        r_resp_err <= 1'b0;
        r_resp_len <= 4'd0;
        r_overflow <= 1'b0;
      end
      if (w_store) begin
        if (w_len_base < MAX_L) begin
          for (int i = 0; i < MAX_LEN; i++)
            if (i == int'(w_len_base)) r_buf[i] <= r_rx_byte;
          r_len <= w_len_base + 4'd1;
        end else begin
          r_ovf_mark <= 1'b1;
        end
      end
      if (w_complete || w_timeout) begin
        for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= 8'h00;
        r_len      <= 4'd0;
        r_ovf_mark <= 1'b0;
      end
      if (w_complete) begin
        r_resp_ok  <= w_ok_match;
        r_resp_err <= w_err_match;
        r_resp_len <= r_len;
        r_overflow <= r_ovf_mark;
      end
    end
  end

  assign rx_byte   = r_rx_byte;
  assign rx_rdy    = r_rx_rdy;
  assign resp_rcvd = r_resp_rcvd;
  assign resp_ok   = r_resp_ok;
  assign resp_err  = r_resp_err;
  assign resp_len  = r_resp_len;
  assign overflow  = r_overflow;
  assign timeout   = w_timeout;

endmodule

// File: tb/tb_bt_resp_rcv.sv
// Directed bench for bt_resp_rcv at BAUD_DIV=16; timeout scenario only when BT_RESP_TIMEOUT_EN is defined.
module tb_bt_resp_rcv;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       clr_resp = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_rdy, resp_rcvd, resp_ok, resp_err, overflow, timeout;
  logic [3:0] resp_len;

  int n_chk = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  int resp_cnt = 0;
  int to_cnt = 0;
  logic [7:0] last_byte = 8'h00;
  int base;
  logic seen;

  bt_resp_rcv #(.BAUD_DIV(BD), .MAX_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_resp(clr_resp),
    .rx_byte(rx_byte), .rx_rdy(rx_rdy), .resp_rcvd(resp_rcvd),
    .resp_ok(resp_ok), .resp_err(resp_err), .resp_len(resp_len),
    .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_rdy) begin
      rx_cnt++;
      last_byte = rx_byte;
    end
    if (resp_rcvd) resp_cnt++;
    if (timeout) to_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop_bit;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
  endtask

  task automatic send_cr();
    send_frame(8'h0D, 1'b1);
  endtask

  task automatic pulse_clr();
    clr_resp = 1'b1;
    @(negedge clk);
    clr_resp = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_held(input string tag, input logic ok, input logic err,
                            input logic [3:0] len, input logic ovf);
    check({tag, "_ok"},  resp_ok,  ok);
    check({tag, "_err"}, resp_err, err);
    check({tag, "_len"}, resp_len, len);
    check({tag, "_ovf"}, overflow, ovf);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_rdy", rx_rdy, 1'b0);
    check("rst_resp_rcvd", resp_rcvd, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check_held("rst", 1'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // "AOK\r\n" back to back
    base = resp_cnt;
    send_str("AOK"); send_cr(); send_frame(8'h0A, 1'b1);
    repeat (10) @(negedge clk);
    check("aok_pulses", resp_cnt - base, 1);
    check("aok_rx_cnt", rx_cnt, 5);
    check("aok_last_byte", last_byte, 8'h0A);
    check_held("aok", 1'b1, 1'b0, 4'd3, 1'b0);

    base = resp_cnt;
    send_str("ERR"); send_cr();
    repeat (4) @(negedge clk);
    check_held("err", 1'b0, 1'b1, 4'd3, 1'b0);
    send_str("CMD"); send_cr();
    repeat (4) @(negedge clk);
    check_held("cmd", 1'b0, 1'b0, 4'd3, 1'b0);
    check("errcmd_pulses", resp_cnt - base, 2);

    send_str("0123456789"); send_cr();
    repeat (4) @(negedge clk);
    check_held("long", 1'b0, 1'b0, 4'd8, 1'b1);
    send_str("AOK"); send_cr();
    repeat (4) @(negedge clk);
    check_held("after_long", 1'b1, 1'b0, 4'd3, 1'b0);

    base = resp_cnt;
    send_cr();
    repeat (4) @(negedge clk);
    check("empty_no_pulse", resp_cnt - base, 0);
    check_held("empty", 1'b1, 1'b0, 4'd3, 1'b0);

    // glitch, then framing error, then a good 'A'
    base = rx_cnt;
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("glitch_ferr_no_rdy", rx_cnt - base, 0);
    send_frame(8'h41, 1'b1);
    repeat (4) @(negedge clk);
    check("good_after_ferr_rdy", rx_cnt - base, 1);
    check("good_after_ferr_byte", last_byte, 8'h41);

    pulse_clr();
    check_held("clr1", 1'b0, 1'b0, 4'd0, 1'b0);

    // clear while resp_rcvd is high: completion wins
    send_str("AOK");
    seen = 1'b0;
    fork
      send_cr();
      begin
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge clk);
          if (resp_rcvd) seen = 1'b1;
        end
        if (seen) begin
          clr_resp = 1'b1;
          @(negedge clk);
          clr_resp = 1'b0;
        end
      end
    join
    repeat (4) @(negedge clk);
    check("race_resp_seen", seen, 1'b1);
    check_held("race", 1'b1, 1'b0, 4'd3, 1'b0);
    pulse_clr();
    check_held("clr2", 1'b0, 1'b0, 4'd0, 1'b0);

    // clear in the middle of a frame leaves that frame intact
    fork
      send_str("AOK");
      begin
        repeat (60) @(negedge clk);
        clr_resp = 1'b1;
        @(negedge clk);
        clr_resp = 1'b0;
      end
    join
    send_cr();
    repeat (4) @(negedge clk);
    check_held("midclr", 1'b1, 1'b0, 4'd3, 1'b0);

    // reset mid-frame drops the partial line
    send_str("AO");
    RX = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    RX = 1'b1;
    @(negedge clk);
    check_held("rst_mid", 1'b0, 1'b0, 4'd0, 1'b0);
    check("rst_mid_rx_byte", rx_byte, 8'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    base = resp_cnt;
    send_str("K"); send_cr();
    repeat (4) @(negedge clk);
    check("after_rst_pulse", resp_cnt - base, 1);
    check_held("after_rst", 1'b0, 1'b0, 4'd1, 1'b0);

`ifdef BT_RESP_TIMEOUT_EN
    send_str("ERR"); send_cr();
    repeat (4) @(negedge clk);
    base = resp_cnt;
    send_str("AO");
    seen = 1'b0;
    for (int k = 0; k < (1 << 20) + 200 && !seen; k++) begin
      @(negedge clk);
      if (timeout) seen = 1'b1;
    end
    check("timeout_seen", seen, 1'b1);
    repeat (4) @(negedge clk);
    check("timeout_no_resp", resp_cnt - base, 0);
    check_held("timeout_held", 1'b0, 1'b1, 4'd3, 1'b0);
    send_str("K"); send_cr();
    repeat (4) @(negedge clk);
    check_held("after_timeout", 1'b0, 1'b0, 4'd1, 1'b0);
`else
    check("no_timeout_pulses", to_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
